// File: rtl/i2s_rx_deserializer.sv
// I2S receive deserializer.
// Oversamples bclk/lrclk/sdata in the clk domain and assembles signed
// left/right words, presented together with a one-clk sample_valid strobe.
// A slot that ends before WIDTH bits were captured raises a one-clk frame_err.
module i2s_rx_deserializer #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             bclk,
   input  logic             lrclk,
   input  logic             sdata,
   output logic [WIDTH-1:0] left_out,
   output logic [WIDTH-1:0] right_out,
   output logic             sample_valid,
   output logic             frame_err
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {WAIT_SYNC, LEFT, RIGHT} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] bclk_sync, lr_sync, sd_sync;
   logic                   bclk_q, lr_prev, left_ok;
   logic [CW-1:0]          bit_cnt;
   logic [WIDTH-2:0]       shift;      // earlier bits of the word; newest bit is appended
   logic [WIDTH-1:0]       left_hold;

   logic                   bclk_s, lr_s, sd_s;
   logic                   rise, change, capture, last_bit;
   logic [WIDTH-1:0]       shift_next;

   assign bclk_s = bclk_sync[SYNC_STAGES-1];
   assign lr_s   = lr_sync[SYNC_STAGES-1];
   assign sd_s   = sd_sync[SYNC_STAGES-1];

   // Rise of the synchronized bit clock; an lrclk change at a rise opens a new slot
   // and its data bit is the I2S one-bit-delay bit, so it is never captured.
   assign rise       = bclk_s & ~bclk_q;
   assign change     = rise & (lr_s != lr_prev);
   assign capture    = rise & ~change & (state != WAIT_SYNC) & (bit_cnt < CNT_FULL);
   assign last_bit   = capture & (bit_cnt == CNT_LAST);
   assign shift_next = {shift, sd_s};

   // Synchronize the three serial inputs and keep the previous bclk for edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bclk_sync <= '0;
         lr_sync   <= '0;
         sd_sync   <= '0;
         bclk_q    <= 1'b0;
      end else begin
         bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bclk};
         lr_sync   <= {lr_sync[SYNC_STAGES-2:0], lrclk};
         sd_sync   <= {sd_sync[SYNC_STAGES-2:0], sdata};
         bclk_q    <= bclk_s;
      end
   end

   // Slot FSM, bit capture and registered output words/strobes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= WAIT_SYNC;
         lr_prev      <= 1'b0;
         left_ok      <= 1'b0;
         bit_cnt      <= '0;
         shift        <= '0;
         left_hold    <= '0;
         left_out     <= '0;
         right_out    <= '0;
         sample_valid <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         frame_err    <= 1'b0;
         if (rise) lr_prev <= lr_s;
         if (change) begin
            // bit_cnt here is still the count of the slot that just ended
            frame_err <= (state != WAIT_SYNC) && (bit_cnt < CNT_FULL);
            bit_cnt   <= '0;
            case (state)
               WAIT_SYNC: if (!lr_s) begin   // a change to 0 is always a full 1->0 edge
                  state   <= LEFT;
                  left_ok <= 1'b0;
               end
               LEFT:      state <= RIGHT;
               RIGHT: begin
                  state   <= LEFT;
                  left_ok <= 1'b0;
               end
               default:   state <= WAIT_SYNC;
            endcase
         end else if (capture) begin
            shift   <= shift_next[WIDTH-2:0];
            bit_cnt <= bit_cnt + CW'(1);
            if (last_bit) begin
               if (state == LEFT) begin
                  left_hold <= shift_next;
                  left_ok   <= 1'b1;
               end else if (left_ok) begin
                  left_out     <= left_hold;
                  right_out    <= shift_next;
                  sample_valid <= 1'b1;
               end
            end
         end
      end
   end
endmodule
